// File: rtl/laser_pkg.sv
// Shared types and constants for the laser sweep scheduler: FSM states,
// frame size, grid width, the 8-bit {y,x} location type and count width.
package laser_pkg;

  localparam int OBJ_NUM = 40;
  localparam int GRID_W  = 4;
  localparam int CNT_W   = 6;
  localparam int PTR_W   = 6;

  typedef logic [2*GRID_W-1:0] loc_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    REQ,
    WAIT,
    SWAP,
    OUT
  } state_t;

  function automatic loc_t makeLoc(input logic [GRID_W-1:0] y, input logic [GRID_W-1:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/laser_pt_buf.sv
// Point buffer for one frame: synchronous write, asynchronous read.
// Reads beyond the last entry return zero.
module laser_pt_buf
  import laser_pkg::*;
#(
  parameter int DEPTH = OBJ_NUM,
  parameter int AW    = PTR_W
) (
  input  logic          CLK,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  loc_t          wdata_i,
  input  logic [AW-1:0] raddr_i,
  output loc_t          rdata_o
);

  loc_t mem_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (we_i && (int'(waddr_i) < DEPTH)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = (int'(raddr_i) < DEPTH) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/laser_sweep_sched.sv
// Two-circle placement scheduler: buffers a frame of points, then alternately
// sweeps one circle over the grid against a fixed one using an external
// coverage engine. Optional macro LASER_EARLY_EXIT_EN stops once a sweep
// leaves its circle where it started.
module laser_sweep_sched #(
  parameter int OBJ_NUM  = laser_pkg::OBJ_NUM,
  parameter int MAX_ITER = 6,
  parameter int GRID_W   = laser_pkg::GRID_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  input  logic [GRID_W-1:0] X,
  input  logic [GRID_W-1:0] Y,
  input  logic [5:0]        PT_RADDR,
  output logic [7:0]        PT_RDATA,
  output logic              ENG_REQ,
  output logic [GRID_W-1:0] ENG_CX,
  output logic [GRID_W-1:0] ENG_CY,
  output logic [GRID_W-1:0] ENG_FX,
  output logic [GRID_W-1:0] ENG_FY,
  input  logic              ENG_ACK,
  input  logic [5:0]        ENG_CNT,
  output logic [GRID_W-1:0] C1X,
  output logic [GRID_W-1:0] C1Y,
  output logic [GRID_W-1:0] C2X,
  output logic [GRID_W-1:0] C2Y,
  output logic              DONE
);

  import laser_pkg::*;

  localparam int LW     = 2 * GRID_W;
  localparam int ITER_W = $clog2(MAX_ITER) + 1;
  localparam logic [LW-1:0]     LAST_CAND = '1;
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(MAX_ITER - 1);
  localparam logic [PTR_W-1:0]  LAST_PT   = PTR_W'(OBJ_NUM - 1);

  state_t            state_q;
  logic [PTR_W-1:0]  wptr_q;
  logic [ITER_W-1:0] iter_q;
  logic [CNT_W-1:0]  bestCnt_q;
  logic [LW-1:0]     bestLoc_q;
  logic [LW-1:0]     cand_q;
  logic [LW-1:0]     fixLoc_q;
  logic [LW-1:0]     sweepLoc_q;
  logic              engReq_q;
  logic              done_q;
  logic [LW-1:0]     c1_q;
  logic [LW-1:0]     c2_q;

  logic              ptWe;
  logic [LW-1:0]     cand_d;
  logic [PTR_W-1:0]  wptr_d;
  logic              converged;

  assign ptWe   = IN_VALID && ((state_q == IDLE) || (state_q == LOAD));
  assign cand_d = cand_q + 1'b1;
  assign wptr_d = wptr_q + 1'b1;

  // A sweep that keeps its circle in place means the pair has settled.
`ifdef LASER_EARLY_EXIT_EN
  assign converged = (bestLoc_q == sweepLoc_q);
`else
  assign converged = 1'b0;
`endif

  laser_pt_buf #(
    .DEPTH (OBJ_NUM),
    .AW    (PTR_W)
  ) u_pt_buf (
    .CLK     (CLK),
    .we_i    (ptWe),
    .waddr_i (wptr_q),
    .wdata_i (makeLoc(Y, X)),
    .raddr_i (PT_RADDR),
    .rdata_o (PT_RDATA)
  );

  // fixLoc_q is the stationary circle; sweepLoc_q is where the sweeping circle
  // sat before the current sweep. SWAP moves the swept circle to bestLoc_q and
  // makes it the new fixed circle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      iter_q     <= '0;
      bestCnt_q  <= '0;
      bestLoc_q  <= '0;
      cand_q     <= '0;
      fixLoc_q   <= '0;
      sweepLoc_q <= '0;
      engReq_q   <= 1'b0;
      done_q     <= 1'b0;
      c1_q       <= '0;
      c2_q       <= '0;
    end else begin
      done_q <= 1'b0;
      c1_q   <= '0;
      c2_q   <= '0;
      case (state_q)
        IDLE: begin
          if (IN_VALID) begin
            wptr_q  <= wptr_d;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (IN_VALID) begin
            if (wptr_q == LAST_PT) begin
              wptr_q     <= '0;
              iter_q     <= '0;
              bestCnt_q  <= '0;
              bestLoc_q  <= '0;
              cand_q     <= '0;
              fixLoc_q   <= '0;
              sweepLoc_q <= '0;
              engReq_q   <= 1'b1;
              state_q    <= REQ;
            end else begin
              wptr_q <= wptr_d;
            end
          end
        end
        REQ: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (ENG_ACK) begin
            if (ENG_CNT >= bestCnt_q) begin
              bestCnt_q <= ENG_CNT;
              bestLoc_q <= cand_q;
            end
            cand_q <= cand_d;
            if (cand_q == LAST_CAND) begin
              engReq_q <= 1'b0;
              state_q  <= SWAP;
            end else begin
              state_q <= REQ;
            end
          end
        end
        SWAP: begin
          fixLoc_q   <= bestLoc_q;
          sweepLoc_q <= fixLoc_q;
          iter_q     <= iter_q + 1'b1;
          if ((iter_q == LAST_ITER) || converged) begin
            done_q  <= 1'b1;
            c1_q    <= bestLoc_q;
            c2_q    <= fixLoc_q;
            state_q <= OUT;
          end else begin
            engReq_q <= 1'b1;
            state_q  <= REQ;
          end
        end
        OUT: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ENG_REQ = engReq_q;
  assign ENG_CX  = cand_q[GRID_W-1:0];
  assign ENG_CY  = cand_q[LW-1:GRID_W];
  assign ENG_FX  = fixLoc_q[GRID_W-1:0];
  assign ENG_FY  = fixLoc_q[LW-1:GRID_W];
  assign C1X     = c1_q[GRID_W-1:0];
  assign C1Y     = c1_q[LW-1:GRID_W];
  assign C2X     = c2_q[GRID_W-1:0];
  assign C2Y     = c2_q[LW-1:GRID_W];
  assign DONE    = done_q;

endmodule

// File: tb/tb_laser_sweep_sched.sv
// Bench for laser_sweep_sched: frame vectors run against a coverage-engine
// model, with expected circle results queued per frame and popped on DONE.
module tb_laser_sweep_sched;

  localparam int OBJ_NUM = 40;

  logic       CLK = 1'b0;
  logic       RST;
  logic       IN_VALID;
  logic [3:0] X, Y;
  logic [5:0] PT_RADDR;
  logic [7:0] PT_RDATA;
  logic       ENG_REQ;
  logic [3:0] ENG_CX, ENG_CY, ENG_FX, ENG_FY;
  logic       ENG_ACK;
  logic [5:0] ENG_CNT;
  logic [3:0] C1X, C1Y, C2X, C2Y;
  logic       DONE;

  laser_sweep_sched dut (
    .CLK      (CLK),
    .RST      (RST),
    .IN_VALID (IN_VALID),
    .X        (X),
    .Y        (Y),
    .PT_RADDR (PT_RADDR),
    .PT_RDATA (PT_RDATA),
    .ENG_REQ  (ENG_REQ),
    .ENG_CX   (ENG_CX),
    .ENG_CY   (ENG_CY),
    .ENG_FX   (ENG_FX),
    .ENG_FY   (ENG_FY),
    .ENG_ACK  (ENG_ACK),
    .ENG_CNT  (ENG_CNT),
    .C1X      (C1X),
    .C1Y      (C1Y),
    .C2X      (C2X),
    .C2Y      (C2Y),
    .DONE     (DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    bit         gapped;
    int         maxDelay;
    int         mode;
    logic [7:0] expC1;
    logic [7:0] expC2;
    int         sweepsFull;
    int         sweepsEarly;
    bit         timed;
  } vec_t;

  typedef struct {
    logic [7:0] c1;
    logic [7:0] c2;
  } exp_t;

  exp_t       sbQ[$];
  exp_t       monExp;
  vec_t       tbl[4];
  logic [7:0] ptsExp[OBJ_NUM];
  int         nChecks = 0;
  int         nErrors = 0;
  int         cyc = 0;
  int         engMode = 0;
  int         engMaxDelay = 0;
  logic       prevDone = 1'b0;

  always @(posedge CLK) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit valid, input logic [7:0] pt);
    IN_VALID = valid;
    X        = pt[3:0];
    Y        = pt[7:4];
    @(posedge CLK);
    #1;
  endtask

  // Engine coverage counts; mode 2 moves the best spot once the fixed circle
  // reaches 0x3A, mode 3 always prefers the cell just after the fixed circle.
  function automatic logic [5:0] engineCount(input int mode, input logic [7:0] cand, input logic [7:0] fix);
    logic [7:0] nextFix;
    nextFix = fix + 8'd1;
    case (mode)
      0: return (cand == 8'h55) ? 6'd40 : 6'd0;
      1: return 6'd10;
      2: begin
        if (cand == 8'h3A) return 6'd20;
        if ((cand == 8'hC7) && (fix == 8'h3A)) return 6'd25;
        return 6'd0;
      end
      default: return (cand == nextFix) ? 6'd5 : 6'd0;
    endcase
  endfunction

  initial begin : engine
    logic [7:0] cand;
    logic [7:0] fix;
    int         d;
    bit         ready;
    ENG_ACK = 1'b0;
    ENG_CNT = '0;
    ready   = 1'b0;
    forever begin
      if (!ready) begin
        @(posedge CLK);
        #1;
      end
      ready = 1'b0;
      if (ENG_REQ === 1'b1) begin
        cand = {ENG_CY, ENG_CX};
        fix  = {ENG_FY, ENG_FX};
        d    = (engMaxDelay > 0) ? int'($urandom_range(engMaxDelay, 0)) : 0;
        repeat (d) begin
          @(posedge CLK);
          #1;
        end
        if (ENG_REQ === 1'b1) begin
          ENG_CNT = engineCount(engMode, cand, fix);
          ENG_ACK = 1'b1;
          for (int k = 0; k < 64; k++) begin
            @(posedge CLK);
            #1;
            if ((ENG_REQ !== 1'b1) || ({ENG_CY, ENG_CX} != cand)) break;
          end
          ENG_ACK = 1'b0;
          ENG_CNT = '0;
          ready   = 1'b1;
        end
      end
    end
  end

  // Result monitor: DONE pops the oldest pending frame; otherwise results stay zero.
  always @(posedge CLK) begin
    #1;
    if (DONE === 1'b1) begin
      checkOutput("doneSingleCycle", {31'd0, prevDone}, 32'd0);
      if (sbQ.size() == 0) begin
        nChecks++;
        nErrors++;
        $display("[TB] FAIL unexpectedDone: got DONE=1, expected no DONE without a pending frame");
      end else begin
        monExp = sbQ.pop_front();
        checkOutput("resultC1", {24'd0, C1Y, C1X}, {24'd0, monExp.c1});
        checkOutput("resultC2", {24'd0, C2Y, C2X}, {24'd0, monExp.c2});
      end
    end else begin
      checkOutput("outputsIdleZero", {16'd0, C1Y, C1X, C2Y, C2X}, 32'd0);
    end
    prevDone = DONE;
  end

  task automatic runFrame(input vec_t v);
    int startCyc;
    int sweeps;
    bit seen;
`ifdef LASER_EARLY_EXIT_EN
    sweeps = v.sweepsEarly;
`else
    sweeps = v.sweepsFull;
`endif
    engMode     = v.mode;
    engMaxDelay = v.maxDelay;
    sbQ.push_back('{v.expC1, v.expC2});
    startCyc = cyc;
    for (int i = 0; i < OBJ_NUM; i++) begin
      ptsExp[i] = 8'($urandom);
      applyStimulus(1'b1, ptsExp[i]);
      if (v.gapped && (i != OBJ_NUM - 1)) applyStimulus(1'b0, ~ptsExp[i]);
    end
    repeat (3) applyStimulus(1'b1, 8'hA5);
    IN_VALID = 1'b0;
    for (int i = 0; i < OBJ_NUM; i++) begin
      PT_RADDR = 6'(i);
      #1;
      checkOutput($sformatf("%s.ptBuf[%0d]", v.name, i), {24'd0, PT_RDATA}, {24'd0, ptsExp[i]});
    end
    seen = 1'b0;
    for (int w = 0; (w < 20000) && !seen; w++) begin
      @(posedge CLK);
      #1;
      if (DONE === 1'b1) seen = 1'b1;
    end
    checkOutput({v.name, ".doneSeen"}, {31'd0, seen}, 32'd1);
    if (seen && v.timed) begin
      checkOutput({v.name, ".cycles"}, cyc - startCyc + 1, OBJ_NUM + sweeps * 512 + sweeps + 1);
    end
    @(posedge CLK);
    #1;
    checkOutput({v.name, ".zeroAfterDone"}, {15'd0, DONE, C1Y, C1X, C2Y, C2X}, 32'd0);
  endtask

  task automatic resetMidSweep();
    int guard;
    engMode     = 0;
    engMaxDelay = 0;
    for (int i = 0; i < OBJ_NUM; i++) applyStimulus(1'b1, 8'($urandom));
    IN_VALID = 1'b0;
    guard = 0;
    while ((ENG_REQ !== 1'b0) && (guard < 2000)) begin
      @(posedge CLK);
      #1;
      guard++;
    end
    checkOutput("rst.sweep1End", {31'd0, guard < 2000}, 32'd1);
    @(posedge CLK);
    #1;
    checkOutput("rst.sweep2Req", {31'd0, ENG_REQ}, 32'd1);
    repeat (11) begin
      @(posedge CLK);
      #1;
    end
    #1;
    RST = 1'b1;
    #1;
    checkOutput("rst.engReqAsync", {31'd0, ENG_REQ}, 32'd0);
    checkOutput("rst.doneLow", {31'd0, DONE}, 32'd0);
    checkOutput("rst.coordsZero", {16'd0, ENG_CY, ENG_CX, ENG_FY, ENG_FX}, 32'd0);
    @(posedge CLK);
    #1;
    checkOutput("rst.engReqNextCycle", {31'd0, ENG_REQ}, 32'd0);
    checkOutput("rst.doneNextCycle", {31'd0, DONE}, 32'd0);
    RST = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  initial begin : timeout
    #2000000;
    $display("[TB] FAIL globalTimeout: got no finish, expected finish before 2000000");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    tbl[0] = '{"sparse55",   1'b0, 0, 0, 8'h55, 8'h55, 6, 3, 1'b1};
    tbl[1] = '{"tiesRandAck", 1'b0, 7, 1, 8'hFF, 8'hFF, 6, 3, 1'b0};
    tbl[2] = '{"gappedWalk", 1'b1, 0, 3, 8'h06, 8'h05, 6, 6, 1'b0};
    tbl[3] = '{"moveOnce",   1'b0, 3, 2, 8'hC7, 8'hC7, 6, 4, 1'b0};

    RST      = 1'b1;
    IN_VALID = 1'b0;
    X        = '0;
    Y        = '0;
    PT_RADDR = '0;
    #12;
    checkOutput("reset.engReq", {31'd0, ENG_REQ}, 32'd0);
    checkOutput("reset.done", {31'd0, DONE}, 32'd0);
    checkOutput("reset.coords", {16'd0, ENG_CY, ENG_CX, ENG_FY, ENG_FX}, 32'd0);
    checkOutput("reset.results", {16'd0, C1Y, C1X, C2Y, C2X}, 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;

    for (int i = 0; i < 4; i++) begin
      $display("[TB] frame %s", tbl[i].name);
      runFrame(tbl[i]);
    end

    $display("[TB] reset during second sweep");
    resetMidSweep();
    runFrame(tbl[0]);

    repeat (5) @(posedge CLK);
    #1;
    checkOutput("scoreboardEmpty", sbQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
